// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port GPR file with write-to-read bypass and sequential clear engine
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     clr_req,
  output logic                     busy
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_clearing;
  logic              w_wr0_ok, w_wr1_ok;

  assign w_clearing = (r_state == ST_CLEAR);
  assign busy       = w_clearing;

  // Writes are masked while clearing and, with a hard-wired R0, when aimed at address 0.
  assign w_wr0_ok = wr0_en && !w_clearing && !((ZERO_R0 != 0) && (wr0_addr == '0));
  assign w_wr1_ok = wr1_en && !w_clearing && !((ZERO_R0 != 0) && (wr1_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_clearing) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_wr0_ok) r_mem[wr0_addr] <= wr0_data;
      if (w_wr1_ok) r_mem[wr1_addr] <= wr1_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_val;
    logic [DATA_W-1:0] r_q;

    assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      w_val = r_mem[w_addr];
      if (w_clearing)                              w_val = '0;
      else if ((ZERO_R0 != 0) && (w_addr == '0))   w_val = '0;
      else if (w_wr1_ok && (wr1_addr == w_addr))   w_val = wr1_data;
      else if (w_wr0_ok && (wr0_addr == w_addr))   w_val = wr0_data;
    end

    always_ff @(posedge clk) begin
      if (rst)             r_q <= '0;
      else if (rd_en[p])   r_q <= w_val;
    end

    assign rd_data[p*DATA_W +: DATA_W] = r_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (ZERO_R0 = 1 and 0 instances)
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic        wr0_en, wr1_en;
  logic [4:0]  wr0_addr, wr1_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        clr_req;
  logic        busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_R0(1)) u_dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .clr_req(clr_req), .busy(busy_a)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_R0(0)) u_dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .clr_req(clr_req), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en   = 2'b00;
    wr0_en  = 1'b0;
    wr1_en  = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_en   = 2'b11;
      rd_addr = {5'(i), 5'(i)};
      tick();
      chk(tag, rd_data_a, 64'h0);
      chk({tag, "_b"}, rd_data_b, 64'h0);
    end
    rd_en = 2'b00;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr0_addr = '0; wr1_addr = '0;
    wr0_data = '0; wr1_data = '0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", {63'h0, busy_a}, 64'h0);
    chk("reset_rd", rd_data_a, 64'h0);

    read_all_zero("reset_read");

    // plain write then read on port 1
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    tick();
    wr0_en = 1'b0;
    rd_en = 2'b10; rd_addr = {5'd5, 5'd0};
    tick();
    chk("wr_rd_p1", rd_data_a[63:32], 64'hDEADBEEF);
    chk("hold_p0", rd_data_a[31:0], 64'h0);

    // same-address collision with same-cycle read
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    tick();
    wr0_en = 1'b0; wr1_en = 1'b0;
    chk("bypass_wr1", rd_data_a[31:0], 64'h22);
    chk("hold_p1", rd_data_a[63:32], 64'hDEADBEEF);
    tick();
    chk("later_r7", rd_data_a[31:0], 64'h22);

    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99;
    rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    tick();
    wr0_en = 1'b0;
    chk("bypass_wr0", rd_data_a[63:32], 64'h99);

    // R0 behaviour on both variants
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
    rd_en = 2'b01; rd_addr = 10'd0;
    tick();
    wr1_en = 1'b0;
    chk("r0_bypass_z", rd_data_a[31:0], 64'h0);
    chk("r0_bypass_nz", rd_data_b[31:0], 64'hFFFFFFFF);
    rd_en = 2'b00;
    tick();
    rd_en = 2'b01; rd_addr = 10'd0;
    tick();
    chk("r0_read_z", rd_data_a[31:0], 64'h0);
    chk("r0_read_nz", rd_data_b[31:0], 64'hFFFFFFFF);
    rd_en = 2'b00;

    for (int i = 1; i < 32; i++) begin
      wr0_en = 1'b1; wr0_addr = 5'(i); wr0_data = 32'(i);
      tick();
    end
    wr0_en = 1'b0;
    rd_en = 2'b11; rd_addr = {5'd31, 5'd1};
    tick();
    chk("fill_r1_r31", rd_data_a, {32'd31, 32'd1});

    // clear engine: count busy cycles, attempt writes and a stray clr_req
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hAB;
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'hCD;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd1};
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      n++;
      clr_req = (n == 5);
      tick();
    end
    idle_inputs();
    chk("clear_busy_cycles", 64'(n), 64'd32);
    chk("clear_rd_zero", rd_data_a[31:0], 64'h0);
    tick();
    chk("clear_no_restart", {63'h0, busy_a}, 64'h0);
    read_all_zero("after_clear");

    // abort a clear with reset; reset also wins over a same-cycle write
    wr0_en = 1'b1; wr0_addr = 5'd20; wr0_data = 32'h55;
    tick();
    wr0_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("abort_busy_pre", {63'h0, busy_a}, 64'h1);
    rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd25; wr0_data = 32'h1234;
    rd_en = 2'b11; rd_addr = {5'd20, 5'd20};
    tick();
    rst = 1'b0;
    idle_inputs();
    chk("abort_busy", {63'h0, busy_a}, 64'h0);
    chk("abort_rd", rd_data_a, 64'h0);
    read_all_zero("abort_read");

    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h5A;
    tick();
    wr0_en = 1'b0;
    rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
    tick();
    chk("post_abort_wr", rd_data_a[63:32], 64'h5A);
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
